id_operand_fetch: RTL and testbench
===================================

// Module: id_operand_fetch
// PURPOSE
//  Decode-stage operand fetch for the 5-stage MIPS pipeline; the requester side of the register file.
//  Takes one instruction from IF/ID and drives the regfile read ports (re1/raddr1, re2/raddr2).
//  Forwards results from EX/MEM, detects load-use hazards and registers operands into ID/EX.
//  Valid/ready handshake on both sides; holds state under EX back-pressure.
// PARAMETERS
//  DW  32  datapath width (fixed 32 for MIPS32; parameter exists for the package constants only)
//  AW  5   register address width
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  in_valid       in   1   IF/ID holds an instruction
//  in_inst        in   32  instruction word
//  in_pc          in   32  instruction PC
//  in_ready       out  1   ID accepts in_inst this cycle
//  re1/raddr1     out  1/5 regfile read port 1 (rs)
//  re2/raddr2     out  1/5 regfile read port 2 (rt)
//  rdata1/rdata2  in   32  regfile read data (already bypasses WB)
//  flush          in   1   kill ID and ID/EX contents (branch redirect)
//  fwd_ex_we      in   1   instruction in EX writes a register
//  fwd_ex_waddr   in   5   destination register in EX
//  fwd_ex_wdata   in   32  EX result
//  fwd_ex_load    in   1   instruction in EX is a load (data not yet available)
//  fwd_mem_we     in   1   instruction in MEM writes a register
//  fwd_mem_waddr  in   5   destination register in MEM
//  fwd_mem_wdata  in   32  MEM result
//  out_valid      out  1   ID/EX holds a valid instruction
//  out_ready      in   1   EX accepts ID/EX this cycle
//  out_inst       out  32  registered instruction word
//  out_pc         out  32  registered PC
//  out_op1        out  32  operand A (forwarded rs)
//  out_op2        out  32  operand B (forwarded rt, or extended immediate)
//  out_sdata      out  32  store data (forwarded rt; 0 for non-stores)
//  out_we         out  1   writes a register
//  out_waddr      out  5   destination register
// BEHAVIOUR
//  Decode: op=0 -> read rs,rt; write rd. op=001xxx -> read rs; write rt; op2 = imm, sign-extended for
//    addi/addiu/slti/sltiu, zero-extended for andi/ori/xori, {imm,16'h0} for lui. op=100xxx -> read rs; write rt;
//    op2 = sign-extended imm. op=101xxx -> read rs,rt; no write; op2 = sign-extended imm; sdata = rt.
//  All other opcodes: no reads, no write, op1 = op2 = 0.
//  re1/re2 are combinational: asserted only when in_valid and the decoded read is needed; otherwise 0.
//    raddr = field value.
//  Forwarding, per operand, raddr!=0 and re: EX match (not a load) > MEM match > rdata. raddr==0 gives 0.
//  Hazard = in_valid && fwd_ex_load && fwd_ex_we && (raddr1 matches with re1, or raddr2 matches with re2).
//    Address 0 never matches.
//  adv = !out_valid || out_ready.
//  in_ready = adv && !hazard && !flush.
//  On a clock edge with adv: ID/EX loads the instruction and out_valid=1 if in_valid && in_ready; otherwise out_valid=0 (bubble).
//  !adv: all out_* held unchanged (forwarded values are captured at load time only).
//  flush: out_valid<=0 next edge regardless of adv; input not consumed. flush beats hazard and back-pressure.
//  Latency: one cycle from in_valid&&in_ready to out_valid.
//  Load-use: one bubble, then the instruction issues using the MEM forward.
//  Reset (async): out_valid=0, all out_* = 0. in_ready/re1/re2 = 0 while rst=1.
// CONFIGURATION
//  ID_MEM_FWD_EN defined: MEM forwarding path as above.
//  ID_MEM_FWD_EN undefined: no MEM path. Any MEM match (fwd_mem_we, addr!=0) is added to hazard and stalls until the
//    value retires to WB and arrives via rdata. fwd_mem_wdata is ignored; ports unchanged.
// STRUCTURE
//  Package id_pkg: opcode/funct localparams (OP_SPECIAL, OP_ADDI..OP_LUI, load/store classes),
//    field bit ranges (RS_MSB..), and the zero-register constant.
//  Sub-module id_fwd_mux: one operand's priority select (EX/MEM/rdata/zero) plus match output for the
//    hazard logic. Instantiated twice.
//  Top: decode, hazard/handshake, ID/EX register.
// TESTING
//  addu $3,$1,$2 with regfile r1=5, r2=7, no forwarding -> next cycle out_op1=5, out_op2=7, out_waddr=3, out_we=1.
//  fwd_ex_we=1, fwd_ex_waddr=1, fwd_ex_wdata=0xAA, plus fwd_mem match on r1 with 0xBB -> out_op1=0xAA (EX wins).
//  lw $4 in EX (fwd_ex_load=1, waddr=4), then addu $5,$4,$4 -> in_ready=0 one cycle and out_valid=0 bubble;
//    next cycle takes MEM forward.
//  ori $6,$0,0x8001 -> re1=1, raddr1=0, out_op1=0, out_op2=0x00008001.
//    addi imm 0x8001 -> out_op2=0xFFFF8001. lui -> 0x80010000.
//  out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0.
//    flush during the stall -> out_valid=0 next edge.
//  rst asserted mid-stream, asynchronous with no clock edge -> out_valid=0 immediately, all outputs 0.
//  Repeat the load-use test with ID_MEM_FWD_EN undefined -> two bubbles, then operands come from rdata.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode constants and the ID/EX bundle for the MIPS operand-fetch stage.
// Build option: ID_MEM_FWD_EN enables the MEM-stage forwarding path.
package id_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  localparam logic [2:0] CLS_IMM   = 3'b001;
  localparam logic [2:0] CLS_LOAD  = 3'b100;
  localparam logic [2:0] CLS_STORE = 3'b101;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    IMM_SEXT,
    IMM_ZEXT,
    IMM_LUI
  } imm_kind_e;

  typedef struct packed {
    logic [DW-1:0] inst;
    logic [DW-1:0] pc;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [DW-1:0] sdata;
    logic          we;
    logic [AW-1:0] waddr;
  } id_ex_t;

  function automatic logic [DW-1:0] ext_imm(
    input logic [15:0] imm,
    input imm_kind_e   kind
  );
    logic [DW-1:0] r;
    unique case (kind)
      IMM_ZEXT: r = {16'h0, imm};
      IMM_LUI:  r = {imm, 16'h0};
      default:  r = {{16{imm[15]}}, imm};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/id_operand_fetch_fwd_mux.sv
// One operand's bypass select: zero register, EX result, MEM result, regfile.
// Build option: ID_MEM_FWD_EN enables the MEM-stage source.
module id_fwd_mux
  import id_pkg::*;
(
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  input  logic [DW-1:0] rdata_i,
  input  logic          ex_we_i,
  input  logic [AW-1:0] ex_waddr_i,
  input  logic [DW-1:0] ex_wdata_i,
  input  logic          ex_load_i,
  input  logic          mem_we_i,
  input  logic [AW-1:0] mem_waddr_i,
  input  logic [DW-1:0] mem_wdata_i,
  output logic [DW-1:0] opnd_o,
  output logic          ex_match_o,
  output logic          mem_match_o
);

  logic is_zero;

  assign is_zero     = (raddr_i == REG_ZERO);
  assign ex_match_o  = re_i && !is_zero && ex_we_i
                       && (ex_waddr_i == raddr_i);
  assign mem_match_o = re_i && !is_zero && mem_we_i
                       && (mem_waddr_i == raddr_i);

  always_comb begin
    opnd_o = rdata_i;
    if (is_zero) begin
      opnd_o = '0;
    end else if (ex_match_o && !ex_load_i) begin
      opnd_o = ex_wdata_i;
`ifdef ID_MEM_FWD_EN
    end else if (mem_match_o) begin
      opnd_o = mem_wdata_i;
`endif
    end
  end

`ifndef ID_MEM_FWD_EN
  // MEM producers stall instead; the data port stays for a fixed interface.
  logic unused_mem_wdata;
  assign unused_mem_wdata = ^mem_wdata_i;
`endif

endmodule

// File: rtl/id_operand_fetch.sv
// Decode-stage operand fetch: decode, bypass, load-use stall, ID/EX register.
// Build option: ID_MEM_FWD_EN enables MEM forwarding (otherwise MEM hits stall).
module id_operand_fetch
  import id_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_inst,
  input  logic [DW-1:0] in_pc,
  output logic          in_ready,
  output logic          re1,
  output logic [AW-1:0] raddr1,
  output logic          re2,
  output logic [AW-1:0] raddr2,
  input  logic [DW-1:0] rdata1,
  input  logic [DW-1:0] rdata2,
  input  logic          flush,
  input  logic          fwd_ex_we,
  input  logic [AW-1:0] fwd_ex_waddr,
  input  logic [DW-1:0] fwd_ex_wdata,
  input  logic          fwd_ex_load,
  input  logic          fwd_mem_we,
  input  logic [AW-1:0] fwd_mem_waddr,
  input  logic [DW-1:0] fwd_mem_wdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_inst,
  output logic [DW-1:0] out_pc,
  output logic [DW-1:0] out_op1,
  output logic [DW-1:0] out_op2,
  output logic [DW-1:0] out_sdata,
  output logic          out_we,
  output logic [AW-1:0] out_waddr
);

  logic [5:0]    op;
  logic [15:0]   imm;
  logic          rd_rs;
  logic          rd_rt;
  logic          wr;
  logic          use_imm;
  logic          is_store;
  logic [AW-1:0] waddr_dec;
  imm_kind_e     kind;

  logic [DW-1:0] opnd1;
  logic [DW-1:0] opnd2;
  logic          ex_m1;
  logic          ex_m2;
  logic          mem_m1;
  logic          mem_m2;
  logic          hazard;
  logic          adv;
  logic          fire;

  id_ex_t        ex_d;
  id_ex_t        ex_q;
  logic          valid_q;

  assign op     = in_inst[OP_MSB:OP_LSB];
  assign imm    = in_inst[IMM_MSB:IMM_LSB];
  assign raddr1 = in_inst[RS_MSB:RS_LSB];
  assign raddr2 = in_inst[RT_MSB:RT_LSB];

  always_comb begin
    rd_rs     = 1'b0;
    rd_rt     = 1'b0;
    wr        = 1'b0;
    use_imm   = 1'b0;
    is_store  = 1'b0;
    waddr_dec = REG_ZERO;
    kind      = IMM_SEXT;
    unique case (1'b1)
      (op == OP_SPECIAL): begin
        rd_rs     = 1'b1;
        rd_rt     = 1'b1;
        wr        = 1'b1;
        waddr_dec = in_inst[RD_MSB:RD_LSB];
      end
      (op[5:3] == CLS_IMM): begin
        rd_rs     = 1'b1;
        wr        = 1'b1;
        use_imm   = 1'b1;
        waddr_dec = in_inst[RT_MSB:RT_LSB];
        if (op == OP_ANDI || op == OP_ORI || op == OP_XORI)
          kind = IMM_ZEXT;
        else if (op == OP_LUI)
          kind = IMM_LUI;
      end
      (op[5:3] == CLS_LOAD): begin
        rd_rs     = 1'b1;
        wr        = 1'b1;
        use_imm   = 1'b1;
        waddr_dec = in_inst[RT_MSB:RT_LSB];
      end
      (op[5:3] == CLS_STORE): begin
        rd_rs    = 1'b1;
        rd_rt    = 1'b1;
        use_imm  = 1'b1;
        is_store = 1'b1;
      end
      default: ;
    endcase
  end

  assign re1 = !rst && in_valid && rd_rs;
  assign re2 = !rst && in_valid && rd_rt;

  id_fwd_mux u_fwd1 (
    .re_i        (re1),
    .raddr_i     (raddr1),
    .rdata_i     (rdata1),
    .ex_we_i     (fwd_ex_we),
    .ex_waddr_i  (fwd_ex_waddr),
    .ex_wdata_i  (fwd_ex_wdata),
    .ex_load_i   (fwd_ex_load),
    .mem_we_i    (fwd_mem_we),
    .mem_waddr_i (fwd_mem_waddr),
    .mem_wdata_i (fwd_mem_wdata),
    .opnd_o      (opnd1),
    .ex_match_o  (ex_m1),
    .mem_match_o (mem_m1)
  );

  id_fwd_mux u_fwd2 (
    .re_i        (re2),
    .raddr_i     (raddr2),
    .rdata_i     (rdata2),
    .ex_we_i     (fwd_ex_we),
    .ex_waddr_i  (fwd_ex_waddr),
    .ex_wdata_i  (fwd_ex_wdata),
    .ex_load_i   (fwd_ex_load),
    .mem_we_i    (fwd_mem_we),
    .mem_waddr_i (fwd_mem_waddr),
    .mem_wdata_i (fwd_mem_wdata),
    .opnd_o      (opnd2),
    .ex_match_o  (ex_m2),
    .mem_match_o (mem_m2)
  );

`ifdef ID_MEM_FWD_EN
  assign hazard = in_valid && fwd_ex_load && (ex_m1 || ex_m2);
`else
  assign hazard = in_valid
                  && ((fwd_ex_load && (ex_m1 || ex_m2))
                      || mem_m1 || mem_m2);
`endif

  assign adv      = !valid_q || out_ready;
  assign in_ready = !rst && adv && !hazard && !flush;
  assign fire     = in_valid && in_ready;

  always_comb begin
    ex_d       = '0;
    ex_d.inst  = in_inst;
    ex_d.pc    = in_pc;
    ex_d.op1   = rd_rs ? opnd1 : '0;
    ex_d.op2   = use_imm ? ext_imm(imm, kind)
               : (rd_rt ? opnd2 : '0);
    ex_d.sdata = is_store ? opnd2 : '0;
    ex_d.we    = wr;
    ex_d.waddr = waddr_dec;
  end

  // Operands are captured only on load; a stall holds them as issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (adv) begin
      valid_q <= fire;
      if (fire) ex_q <= ex_d;
    end
  end

  assign out_valid = valid_q;
  assign out_inst  = ex_q.inst;
  assign out_pc    = ex_q.pc;
  assign out_op1   = ex_q.op1;
  assign out_op2   = ex_q.op2;
  assign out_sdata = ex_q.sdata;
  assign out_we    = ex_q.we;
  assign out_waddr = ex_q.waddr;

endmodule

// File: tb/tb_id_operand_fetch.sv
// Directed bench for id_operand_fetch; follows ID_MEM_FWD_EN like the RTL.
// Build option: ID_MEM_FWD_EN selects the load-use expectations.
module tb_id_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        re1;
  logic [4:0]  raddr1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        flush;
  logic        fwd_ex_we;
  logic [4:0]  fwd_ex_waddr;
  logic [31:0] fwd_ex_wdata;
  logic        fwd_ex_load;
  logic        fwd_mem_we;
  logic [4:0]  fwd_mem_waddr;
  logic [31:0] fwd_mem_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [31:0] out_sdata;
  logic        out_we;
  logic [4:0]  out_waddr;

  logic [31:0] rf [32];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];

  id_operand_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_inst       (in_inst),
    .in_pc         (in_pc),
    .in_ready      (in_ready),
    .re1           (re1),
    .raddr1        (raddr1),
    .re2           (re2),
    .raddr2        (raddr2),
    .rdata1        (rdata1),
    .rdata2        (rdata2),
    .flush         (flush),
    .fwd_ex_we     (fwd_ex_we),
    .fwd_ex_waddr  (fwd_ex_waddr),
    .fwd_ex_wdata  (fwd_ex_wdata),
    .fwd_ex_load   (fwd_ex_load),
    .fwd_mem_we    (fwd_mem_we),
    .fwd_mem_waddr (fwd_mem_waddr),
    .fwd_mem_wdata (fwd_mem_wdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_op1       (out_op1),
    .out_op2       (out_op2),
    .out_sdata     (out_sdata),
    .out_we        (out_we),
    .out_waddr     (out_waddr)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  task automatic fwd_clear();
    fwd_ex_we     = 1'b0;
    fwd_ex_waddr  = '0;
    fwd_ex_wdata  = '0;
    fwd_ex_load   = 1'b0;
    fwd_mem_we    = 1'b0;
    fwd_mem_waddr = '0;
    fwd_mem_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    rf[4] = 32'h99;
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    fwd_clear();
    drive(32'h0022_1821, 32'h100);

    // reset: handshake and read enables forced low
    #2;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_inrdy", {31'b0, in_ready}, 32'd0);
    chk("rst_re1", {31'b0, re1}, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // addu $3,$1,$2 from regfile
    #1;
    chk("a_inrdy", {31'b0, in_ready}, 32'd1);
    chk("a_re", {30'b0, re1, re2}, 32'd3);
    chk("a_raddr", {22'b0, raddr1, raddr2}, {22'b0, 5'd1, 5'd2});
    tick();
    chk("a_valid", {31'b0, out_valid}, 32'd1);
    chk("a_op1", out_op1, 32'd5);
    chk("a_op2", out_op2, 32'd7);
    chk("a_waddr", {27'b0, out_waddr}, 32'd3);
    chk("a_we", {31'b0, out_we}, 32'd1);
    chk("a_pc", out_pc, 32'h100);
    chk("a_sdata", out_sdata, 32'd0);

    // EX beats MEM on r1
    drive(32'h0022_1821, 32'h104);
    fwd_ex_we = 1'b1; fwd_ex_waddr = 5'd1; fwd_ex_wdata = 32'hAA;
    fwd_mem_we = 1'b1; fwd_mem_waddr = 5'd1; fwd_mem_wdata = 32'hBB;
    #1;
`ifndef ID_MEM_FWD_EN
    chk("b_memstall", {31'b0, in_ready}, 32'd0);
    fwd_mem_we = 1'b0;
    #1;
`endif
    chk("b_inrdy", {31'b0, in_ready}, 32'd1);
    tick();
    chk("b_op1", out_op1, 32'hAA);
    chk("b_op2", out_op2, 32'd7);
    fwd_clear();

    // load-use: addu $5,$4,$4 behind lw $4
    drive(32'h0084_2821, 32'h108);
    fwd_ex_we = 1'b1; fwd_ex_waddr = 5'd4;
    fwd_ex_wdata = 32'hDEAD; fwd_ex_load = 1'b1;
    #1;
    chk("c_hz_inrdy", {31'b0, in_ready}, 32'd0);
    tick();
    chk("c_bubble1", {31'b0, out_valid}, 32'd0);
    fwd_clear();
    fwd_mem_we = 1'b1; fwd_mem_waddr = 5'd4; fwd_mem_wdata = 32'h44;
    #1;
`ifdef ID_MEM_FWD_EN
    chk("c_inrdy", {31'b0, in_ready}, 32'd1);
    tick();
`else
    chk("c_mem_hz", {31'b0, in_ready}, 32'd0);
    tick();
    chk("c_bubble2", {31'b0, out_valid}, 32'd0);
    fwd_clear();
    rf[4] = 32'h44;
    #1;
    chk("c_inrdy", {31'b0, in_ready}, 32'd1);
    tick();
`endif
    chk("c_valid", {31'b0, out_valid}, 32'd1);
    chk("c_op1", out_op1, 32'h44);
    chk("c_op2", out_op2, 32'h44);
    chk("c_waddr", {27'b0, out_waddr}, 32'd5);
    fwd_clear();

    // immediates: ori, addi, lui
    drive(32'h3406_8001, 32'h10C);
    #1;
    chk("d_re", {30'b0, re1, re2}, 32'd2);
    chk("d_raddr1", {27'b0, raddr1}, 32'd0);
    tick();
    chk("d_ori_op1", out_op1, 32'd0);
    chk("d_ori_op2", out_op2, 32'h0000_8001);
    chk("d_ori_wa", {27'b0, out_waddr}, 32'd6);
    drive(32'h2027_8001, 32'h110);
    tick();
    chk("d_addi_op1", out_op1, 32'd5);
    chk("d_addi_op2", out_op2, 32'hFFFF_8001);
    drive(32'h3C08_8001, 32'h114);
    tick();
    chk("d_lui_op2", out_op2, 32'h8001_0000);

    // store sw $2,4($1), then jump (no operands)
    drive(32'hAC22_0004, 32'h118);
    tick();
    chk("e_sw_op1", out_op1, 32'd5);
    chk("e_sw_op2", out_op2, 32'd4);
    chk("e_sw_sd", out_sdata, 32'd7);
    chk("e_sw_we", {31'b0, out_we}, 32'd0);
    drive(32'h0800_0010, 32'h11C);
    #1;
    chk("e_j_re", {30'b0, re1, re2}, 32'd0);
    tick();
    chk("e_j_valid", {31'b0, out_valid}, 32'd1);
    chk("e_j_op", out_op1 | out_op2, 32'd0);
    chk("e_j_we", {31'b0, out_we}, 32'd0);

    // back-pressure hold, then flush
    drive(32'h0022_1821, 32'h120);
    tick();
    out_ready = 1'b0;
    drive(32'h3406_8001, 32'h124);
    fwd_ex_we = 1'b1; fwd_ex_waddr = 5'd1; fwd_ex_wdata = 32'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("f_inrdy", {31'b0, in_ready}, 32'd0);
      tick();
      chk("f_valid", {31'b0, out_valid}, 32'd1);
      chk("f_op1", out_op1, 32'd5);
      chk("f_pc", out_pc, 32'h120);
    end
    fwd_clear();
    flush = 1'b1;
    #1;
    chk("f_fl_inrdy", {31'b0, in_ready}, 32'd0);
    tick();
    chk("f_fl_valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0;
    tick();
    chk("f_ori_valid", {31'b0, out_valid}, 32'd1);
    chk("f_ori_pc", out_pc, 32'h124);
    chk("f_ori_wa", {27'b0, out_waddr}, 32'd6);

    // asynchronous reset between edges
    rst = 1'b1;
    #1;
    chk("g_valid", {31'b0, out_valid}, 32'd0);
    chk("g_op2", out_op2, 32'd0);
    chk("g_pc", out_pc, 32'd0);
    chk("g_wa", {26'b0, out_we, out_waddr}, 32'd0);
    chk("g_inrdy", {30'b0, in_ready, re1}, 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
